alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_alu16bit.sv | 80 ++++++++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// ALU op codes, FSM states and a saturating counter helper.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SEXT = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NONE = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SGT  = 4'd11;
    localparam logic [3:0] OP_CLZO = 4'd12;
    localparam logic [3:0] OP_SRL  = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_SRA  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu16bit.sv
// Combinational ALU. SEXT: B=0 sign-extends, B=1 zero-extends the low byte.
// SRL rotates right when B[MSB] is set; CLZO counts leading bits equal to B[0].
module ALU16Bit
    import alu_arbiter_pkg::*;
#(
    parameter int n = 16
) (
    input  logic [3:0]   op_i,
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic [n-1:0] y_o
);

    localparam int SW = $clog2(n);
    localparam int CW = $clog2(n + 1);

    logic [SW-1:0] sh;
    logic [SW-1:0] nsh;
    logic [n-1:0]  prod;
    logic [CW-1:0] clz;
    logic          clz_done;

    assign sh   = b_i[SW-1:0];
    assign nsh  = '0 - sh;
    assign prod = a_i * b_i;

    // Count leading bits of A that match the selected polarity
    always_comb begin
        clz      = '0;
        clz_done = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!clz_done) begin
                if (a_i[i] == b_i[0]) begin
                    clz = clz + CW'(1);
                end else begin
                    clz_done = 1'b1;
                end
            end
        end
    end

    // Operation select
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_ADD:  y_o = a_i + b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SEXT: begin
                if (b_i[0]) begin
                    y_o = {{(n-8){1'b0}}, a_i[7:0]};
                end else begin
                    y_o = {{(n-8){a_i[7]}}, a_i[7:0]};
                end
            end
            OP_SUB:  y_o = a_i - b_i;
            OP_SLT:  y_o = {{(n-1){1'b0}},
                            $signed(a_i) < $signed(b_i)};
            OP_NONE: y_o = '0;
            OP_MUL:  y_o = prod;
            OP_SLL:  y_o = a_i << sh;
            OP_SGT:  y_o = {{(n-1){1'b0}},
                            $signed(a_i) > $signed(b_i)};
            OP_CLZO: y_o = {{(n-CW){1'b0}}, clz};
            OP_SRL: begin
                if (b_i[n-1]) begin
                    y_o = (a_i >> sh) | (a_i << nsh);
                end else begin
                    y_o = a_i >> sh;
                end
            end
            OP_SLTU: y_o = {{(n-1){1'b0}}, a_i < b_i};
            OP_SRA:  y_o = $signed(a_i) >>> sh;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter for two ALU requesters; one operation in flight,
// IDLE accepts, EXEC computes on registered operands, RESP holds the result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [15:0]  done_cnt0,
    output logic [15:0]  done_cnt1
);

    state_e       state_q, state_d;
    logic         last_q, last_d;
    logic         id_q, id_d;
    logic [3:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_result_q, rsp_result_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_err_q, rsp_err_d;
    logic [15:0]  done_cnt0_q, done_cnt0_d;
    logic [15:0]  done_cnt1_q, done_cnt1_d;

    logic         gnt_any;
    logic         gnt_id;
    logic         reject;
    logic [N-1:0] alu_y;

    ALU16Bit #(
        .n (N)
    ) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    // Grant: lone requester wins, ties go to whoever was not served last
    always_comb begin
        gnt_any = rst_n && (state_q == S_IDLE)
                  && (req0_valid || req1_valid);
        gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    end

    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;

    assign reject = (op_q == OP_NONE)
                    || ((op_q == OP_SEXT) && (b_q > N'(1)));

    // Next-state and datapath capture for the three-phase sequence
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        done_cnt0_d  = done_cnt0_q;
        done_cnt1_d  = done_cnt1_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    op_d    = gnt_id ? req1_op : req0_op;
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_id_d     = id_q;
                rsp_err_d    = reject;
                rsp_result_d = reject ? '0 : alu_y;
                rsp_zero_d   = reject || (alu_y == '0);
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if (rsp_id_q) begin
                        done_cnt1_d = sat_inc(done_cnt1_q);
                    end else begin
                        done_cnt0_d = sat_inc(done_cnt0_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
            rsp_err_q    <= 1'b0;
            done_cnt0_q  <= '0;
            done_cnt1_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            done_cnt0_q  <= done_cnt0_d;
            done_cnt1_q  <= done_cnt1_d;
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign done_cnt0  = done_cnt0_q;
    assign done_cnt1  = done_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table through both requesters,
// then round-robin, reject, back-pressure, abort and saturation sequences.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_err;
    logic [15:0] done_cnt0, done_cnt1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        k;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    alu_arbiter #(.N(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_req(input logic k, input logic v,
                           input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        if (k) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Wait (bounded) for a grant; returns just after the accept edge
    task automatic wait_grant(output logic gid);
        bit ok;
        ok = 1'b0;
        gid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                gid = req1_ready;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_timeout: got no ready expected ready");
        end
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge: checks latency and payload
    task automatic finish_rsp(input string nm, input logic id,
                              input logic [15:0] res, input logic err);
        chk({nm, "_exec"}, rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({nm, "_lat"}, rsp_valid, 1'b1);
        chk(nm, {rsp_id, rsp_err, rsp_zero, rsp_result},
            {id, err, (res == 16'h0), res});
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic gid;
        @(negedge clk);
        set_req(v.k, 1'b1, v.op, v.a, v.b);
        #1;
        wait_grant(gid);
        set_req(v.k, 1'b0, v.op, v.a, v.b);
        finish_rsp(nm, v.k, v.res, v.err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic gid;
        vec_t v;

        tv.push_back('{1'b0, 4'd2,  16'h0003, 16'h0004, 16'h0007, 1'b0});
        tv.push_back('{1'b1, 4'd0,  16'hF0F0, 16'hFF00, 16'hF000, 1'b0});
        tv.push_back('{1'b0, 4'd1,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0});
        tv.push_back('{1'b1, 4'd3,  16'h0000, 16'h0000, 16'hFFFF, 1'b0});
        tv.push_back('{1'b0, 4'd4,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b0});
        tv.push_back('{1'b1, 4'd5,  16'h0080, 16'h0000, 16'hFF80, 1'b0});
        tv.push_back('{1'b0, 4'd5,  16'h1280, 16'h0001, 16'h0080, 1'b0});
        tv.push_back('{1'b1, 4'd5,  16'h0080, 16'h0002, 16'h0000, 1'b1});
        tv.push_back('{1'b0, 4'd6,  16'h0005, 16'h0005, 16'h0000, 1'b0});
        tv.push_back('{1'b1, 4'd6,  16'h0000, 16'h0001, 16'hFFFF, 1'b0});
        tv.push_back('{1'b0, 4'd7,  16'hFFFF, 16'h0001, 16'h0001, 1'b0});
        tv.push_back('{1'b1, 4'd14, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
        tv.push_back('{1'b0, 4'd11, 16'h0001, 16'hFFFF, 16'h0001, 1'b0});
        tv.push_back('{1'b1, 4'd8,  16'h1234, 16'h5678, 16'h0000, 1'b1});
        tv.push_back('{1'b0, 4'd9,  16'h0100, 16'h0100, 16'h0000, 1'b0});
        tv.push_back('{1'b1, 4'd9,  16'h000C, 16'h000D, 16'h009C, 1'b0});
        tv.push_back('{1'b0, 4'd10, 16'h0001, 16'h0004, 16'h0010, 1'b0});
        tv.push_back('{1'b1, 4'd13, 16'h8000, 16'h000F, 16'h0001, 1'b0});
        tv.push_back('{1'b0, 4'd13, 16'h0001, 16'h8001, 16'h8000, 1'b0});
        tv.push_back('{1'b1, 4'd15, 16'h8000, 16'h0004, 16'hF800, 1'b0});
        tv.push_back('{1'b0, 4'd12, 16'h00FF, 16'h0000, 16'h0008, 1'b0});
        tv.push_back('{1'b1, 4'd12, 16'hFF00, 16'h0001, 16'h0008, 1'b0});
        tv.push_back('{1'b0, 4'd12, 16'h0000, 16'h0000, 16'h0010, 1'b0});

        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        do_reset();

        chk("reset_state",
            {rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_result,
             done_cnt0, done_cnt1, req0_ready, req1_ready},
            {1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0});

        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            run_vec(v, $sformatf("vec%0d", i));
        end

        // Round robin with both requesters held valid
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        set_req(1'b0, 1'b1, 4'd6, 16'h0005, 16'h0005);
        set_req(1'b1, 1'b1, 4'd1, 16'h0001, 16'h0002);
        #1;
        for (int r = 0; r < 4; r++) begin
            wait_grant(gid);
            chk($sformatf("rr_grant%0d", r), gid, r[0]);
            finish_rsp($sformatf("rr_rsp%0d", r), r[0],
                       r[0] ? 16'h0003 : 16'h0000, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_counts", {done_cnt0, done_cnt1}, {16'd2, 16'd2});

        // Rejected operations from requester 1
        do_reset();
        v = '{1'b1, 4'd8, 16'h0005, 16'h0006, 16'h0000, 1'b1};
        run_vec(v, "rej_none");
        v = '{1'b1, 4'd5, 16'h00FF, 16'h0002, 16'h0000, 1'b1};
        run_vec(v, "rej_sext");
        @(posedge clk);
        #1;
        chk("rej_cnt1", {done_cnt0, done_cnt1}, {16'd0, 16'd2});

        // Back-pressure: response held five cycles
        do_reset();
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 4'd4, 16'h00FF, 16'h0F0F);
        set_req(1'b1, 1'b1, 4'd1, 16'h0001, 16'h0002);
        #1;
        wait_grant(gid);
        chk("hold_grant", gid, 1'b0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d", c),
                {rsp_valid, req0_ready, req1_ready, rsp_id,
                 rsp_err, rsp_zero, rsp_result},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release",
            {rsp_valid, req1_ready, done_cnt0},
            {1'b0, 1'b1, 16'd1});
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_req1", {rsp_valid, done_cnt1}, {1'b0, 16'd0});

        // Reset during EXEC aborts the operation
        @(negedge clk);
        set_req(1'b0, 1'b1, 4'd2, 16'h0001, 16'h0001);
        #1;
        wait_grant(gid);
        rst_n = 1'b0;
        set_req(1'b0, 1'b1, 4'd2, 16'h0010, 16'h0020);
        set_req(1'b1, 1'b1, 4'd1, 16'h0001, 16'h0002);
        @(posedge clk);
        #1;
        chk("rst_ready_low", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_quiet%0d", c),
                {rsp_valid, done_cnt0, done_cnt1}, 33'h0);
        end
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        wait_grant(gid);
        chk("abort_tie", gid, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        finish_rsp("abort_rsp", 1'b0, 16'h0030, 1'b0);

        // Counter saturation
        @(posedge clk);
        @(negedge clk);
        force dut.done_cnt0_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.done_cnt0_q;
        chk("sat_preload", done_cnt0, 16'hFFFE);
        for (int c = 0; c < 3; c++) begin
            v = '{1'b0, 4'd2, 16'h0001, 16'h0001, 16'h0002, 1'b0};
            run_vec(v, $sformatf("sat_op%0d", c));
        end
        @(posedge clk);
        #1;
        chk("sat_cnt0", done_cnt0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
